// File: rtl/input_buffer_reader.sv
// Read-side sequencer: walks an input-buffer address range and streams the words out over valid/ready.
// Optional macro INPUT_BUFFER_READER_STRIDE_EN adds a stride input, so the address advances by stride instead of 1.
module input_buffer_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef INPUT_BUFFER_READER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  buf_rd_en,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [DATA_WIDTH-1:0] buf_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] step_q, step_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_last_q, rd_last_d;
    beat_t                 fifo_q [2];
    beat_t                 fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  push;
    logic                  pop;
    logic [1:0]            occ;
    logic                  issue;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH-1:0] issue_step;
    logic [ADDR_WIDTH-1:0] start_step;

`ifdef INPUT_BUFFER_READER_STRIDE_EN
    assign start_step = stride;
`else
    assign start_step = ADDR_WIDTH'(1);
`endif

    assign m_valid     = (count_q != 2'd0);
    assign m_data      = fifo_q[rd_ptr_q].data;
    assign m_last      = fifo_q[rd_ptr_q].last & m_valid;
    assign busy        = busy_q;
    assign done        = done_q;
    assign buf_rd_en   = issue;
    assign buf_rd_addr = issue_addr;

    // The read strobe is combinational so that a beat popped this cycle frees its
    // slot immediately; that is what sustains 1 beat/cycle with only two entries.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
        state_d    = state_q;
        addr_d     = addr_q;
        step_d     = step_q;
        len_d      = len_q;
        issued_d   = issued_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_vld_d   = 1'b0;
        rd_last_d  = 1'b0;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = addr_q;
        issue_step = step_q;

        push    = rd_vld_q;
        pop     = m_valid & m_ready;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        occ     = count_q + {1'b0, rd_vld_q} - {1'b0, pop};

        if (push) begin
            fifo_d[wr_ptr_q] = '{last: rd_last_q, data: buf_rd_data};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d   = 1'b1;
                    len_d    = length;
                    step_d   = start_step;
                    issued_d = '0;
                    if (length == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // First read goes out in the start cycle itself.
                        issue      = 1'b1;
                        issue_addr = base_addr;
                        issue_step = start_step;
                        issue_last = (length == LEN_WIDTH'(1));
                        state_d    = issue_last ? S_DRAIN : S_READ;
                    end
                end
            end
            S_READ: begin
                if (occ < 2'd2) begin
                    issue      = 1'b1;
                    issue_last = ((issued_q + LEN_WIDTH'(1)) == len_q);
                    if (issue_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (count_d == 2'd0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            rd_vld_d  = 1'b1;
            rd_last_d = issue_last;
            addr_d    = issue_addr + issue_step;
            issued_d  = issued_d + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            step_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            // NOTE: the two skid entries are reset because the head drives m_data, which must read 0 out of reset.
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            step_q    <= step_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Buffered entries plus the read returning this cycle never exceed the skid depth.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, count_q} + {2'b00, rd_vld_q}) <= 3'd2);

    a_stream_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule

// File: tb/tb_input_buffer_reader.sv
// Randomized bench: a behavioural buffer plus an expected-address/expected-beat queue model of the transfer.
module tb_input_buffer_reader;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
`ifdef INPUT_BUFFER_READER_STRIDE_EN
    logic [AW-1:0] stride;
`endif
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [DW-1:0] buf_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    input_buffer_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
`ifdef INPUT_BUFFER_READER_STRIDE_EN
        .stride      (stride),
`endif
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Behavioural input buffer with 1-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_beats[$];
    logic [AW-1:0] exp_addrs[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 0;
    int start_cyc, first_valid_cyc, last_hs_cyc, done_cyc, done_cnt;
    int outstanding, max_out, hs_cnt;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: compares every read strobe and every handshake against the model queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_last", m_last, prev_last);
            end
            if (buf_rd_en) begin
                if (exp_addrs.size() == 0) check("extra_read", 1, 0);
                else check("rd_addr", buf_rd_addr, exp_addrs.pop_front());
                outstanding++;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && exp_beats.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else if (m_valid && m_ready) begin
                beat_t b;
                b = exp_beats.pop_front();
                check("beat_data", m_data, b.data);
                check("beat_last", m_last, b.last);
                if (b.last) last_hs_cyc = cyc;
                outstanding--;
                hs_cnt++;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 2 == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_xfer(input logic [AW-1:0] b, input int n, input logic [AW-1:0] s,
                            input int mode, input int glitch_at);
        int a;
        rdy_mode        = mode;
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
        done_cyc        = -1;
        done_cnt        = 0;
        max_out         = 0;
        step();
        start     = 1'b1;
        base_addr = b;
        length    = LW'(n);
`ifdef INPUT_BUFFER_READER_STRIDE_EN
        stride    = s;
`endif
        start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
`ifdef INPUT_BUFFER_READER_STRIDE_EN
            a = (int'(b) + i * int'(s)) % DEPTH;
`else
            a = (int'(b) + i) % DEPTH;
`endif
            exp_addrs.push_back(AW'(a));
            exp_beats.push_back('{data: mem[a], last: (i == n - 1)});
        end
        step();
        start = 1'b0;
        for (int t = 0; t < 400 && done_cnt == 0; t++) begin
            step();
            start = (t == glitch_at);
            if (start) begin
                base_addr = b + AW'(100);
                length    = LW'(5);
            end
        end
        start = 1'b0;
        check("done_seen", done_cnt, 1);
        check("busy_clear", busy, 0);
        check("beats_left", exp_beats.size(), 0);
        check("reads_left", exp_addrs.size(), 0);
        check("max_outstanding_le2", max_out <= 2, 1);
        if (n > 0) begin
            check("first_valid_latency", first_valid_cyc - start_cyc, 2);
            check("done_after_last", done_cyc, last_hs_cyc + 1);
        end else begin
            check("zero_len_done_within2", (done_cyc - start_cyc) <= 2, 1);
            check("zero_len_no_valid", first_valid_cyc, -1);
        end
        repeat (3) step();
        check("single_done", done_cnt, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        rst_n     = 1'b0;
        start     = 1'b0;
        m_ready   = 1'b0;
        base_addr = '0;
        length    = '0;
`ifdef INPUT_BUFFER_READER_STRIDE_EN
        stride    = AW'(1);
`endif
        hs_cnt    = 0;
        #12;
        check("rst_rd_en", buf_rd_en, 0);
        check("rst_rd_addr", buf_rd_addr, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #10 rst_n = 1'b1;
        repeat (2) step();
        check("idle_busy", busy, 0);

        run_xfer(AW'(5), 4, AW'(1), 0, -1);
        check("basic_streaming", last_hs_cyc - first_valid_cyc, 3);
        run_xfer(AW'(0), 8, AW'(1), 1, -1);
        run_xfer(AW'(1022), 4, AW'(1), 0, -1);
        run_xfer(AW'(300), 0, AW'(1), 0, -1);
        run_xfer(AW'(40), 8, AW'(1), 1, 3);

        // Reset in the middle of a 16-word transfer, then a clean 2-word transfer.
        rdy_mode        = 0;
        hs_cnt          = 0;
        first_valid_cyc = -1;
        step();
        start     = 1'b1;
        base_addr = AW'(100);
        length    = LW'(16);
        for (int i = 0; i < 16; i++) begin
            exp_addrs.push_back(AW'(100 + i));
            exp_beats.push_back('{data: mem[100 + i], last: (i == 15)});
        end
        step();
        start = 1'b0;
        for (int t = 0; t < 50 && hs_cnt < 3; t++) step();
        check("rst_mid_reached_3_beats", hs_cnt, 3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rd_en", buf_rd_en, 0);
        check("rst_mid_rd_addr", buf_rd_addr, 0);
        check("rst_mid_valid", m_valid, 0);
        check("rst_mid_data", m_data, 0);
        check("rst_mid_last", m_last, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        exp_beats.delete();
        exp_addrs.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_xfer(AW'(0), 2, AW'(1), 0, -1);

        for (int k = 0; k < 6; k++) begin
            logic [AW-1:0] s;
`ifdef INPUT_BUFFER_READER_STRIDE_EN
            s = (k == 0) ? AW'(0) : AW'($urandom);
`else
            s = AW'(1);
`endif
            run_xfer(AW'($urandom), int'($urandom_range(1, 24)), s, 2, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_buffer_reader.md
Name: input_buffer_reader

Overview:
- Read-side sequencer for the accelerator's on-chip input buffer.
- On start, walks a programmed address range of the buffer (1-cycle synchronous read latency) and streams the words to the compute datapath over a valid/ready interface.
- Absorbs downstream backpressure with a 2-entry skid FIFO; reports busy/done to the control FSM.

Parameters:
- DATA_WIDTH, 16, width of one buffer word / stream beat
- ADDR_WIDTH, 10, buffer address width; buffer depth = 2**ADDR_WIDTH
- LEN_WIDTH, ADDR_WIDTH+1, width of transfer length (allows full-depth transfer)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  1-cycle pulse; launches a transfer when idle
- base_addr  in  ADDR_WIDTH  first buffer address, sampled on accepted start
- length  in  LEN_WIDTH  number of words, sampled on accepted start
- buf_rd_en  out  1  read strobe to input buffer
- buf_rd_addr  out  ADDR_WIDTH  read address to input buffer
- buf_rd_data  in  DATA_WIDTH  buffer data, valid the cycle after buf_rd_en
- m_valid  out  1  stream beat valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  stream beat
- m_last  out  1  asserted with final beat of transfer
- busy  out  1  transfer in progress
- done  out  1  1-cycle pulse when final beat accepted (or len=0 completes)

Behaviour:
- Reset values: buf_rd_en=0, buf_rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0; FSM=IDLE, FIFO empty, counters 0.
- FSM states IDLE, READ, DRAIN, DONE.
- IDLE: start=1 latches base_addr/length, busy=1; length!=0 -> READ, length==0 -> DONE.
- READ: issue buf_rd_en with buf_rd_addr=current address whenever (FIFO count + reads in flight) < 2; address increments by 1 per issued read, wraps modulo 2**ADDR_WIDTH; when issued count == length -> DRAIN.
- DRAIN: no reads; when FIFO empty and no read in flight -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, -> IDLE.
- Read data enters FIFO the cycle after buf_rd_en; FIFO head drives m_data/m_valid; beat pops when m_valid && m_ready.
- Throughput: 1 beat/cycle with m_ready held high; first m_valid 2 cycles after start (start cycle + read latency).
- m_last=1 only on beat whose index == length-1; tracked per FIFO entry.
- m_data/m_last stable while m_valid=1 && m_ready=0 (AXI-stream rules); m_valid never drops without a handshake.
- start while busy: ignored, no effect on current transfer.
- Simultaneous FIFO push and pop: count unchanged, order preserved.
- rst_n assertion mid-transfer: all state returns to reset values immediately; in-flight read data discarded.

Optional Feature:
- Macro INPUT_BUFFER_READER_STRIDE_EN.
- Defined: extra input port stride (ADDR_WIDTH bits), sampled on accepted start; address advances by stride per read (wrap modulo 2**ADDR_WIDTH); stride=0 re-reads base_addr length times.
- Undefined: no stride port; increment fixed at 1.

Test Plan:
- Reset then idle: all outputs 0; start with base=5,len=4, m_ready=1 -> reads addr 5,6,7,8; m_data = buffer[5..8] on consecutive cycles, m_last on 4th, done pulse 1 cycle after last handshake.
- Backpressure: base=0,len=8, m_ready toggling 1010... -> all 8 words delivered in order, no loss/duplication, m_data stable while stalled, never >2 reads outstanding.
- Wrap: base=1022,len=4 (ADDR_WIDTH=10) -> addresses 1022,1023,0,1; m_last on word from addr 1.
- Zero length: start with len=0 -> no buf_rd_en, no m_valid, done pulses within 2 cycles, busy clears.
- Start while busy: second start mid-transfer with different base -> ignored, original stream completes unchanged, single done pulse.
- Reset mid-transfer: assert rst_n=0 after 3 beats of len=16 -> outputs at reset values immediately; new start base=0,len=2 afterwards -> clean 2-beat transfer.
